// File: rtl/target_hit_pkg.sv
// Shared types and helpers for the target hit tracker.
package target_hit_pkg;

    // Per-channel life cycle.
    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        HIT,
        MISS
    } chan_state_t;

    // Debounce counter width. It must be able to hold DEBOUNCE itself.
    function automatic int unsigned dbc_cnt_w(input int unsigned debounce);
        return $clog2(debounce + 1);
    endfunction

    // Adds a and b and clamps the sum to the largest value of `width` bits.
    // Callers keep width below 64.
    function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                            input int unsigned width);
        logic [64:0] sum;
        logic [64:0] max_val;
        sum     = {1'b0, a} + {1'b0, b};
        max_val = (65'd1 << width) - 65'd1;
        if (sum > max_val) begin
            return max_val[63:0];
        end
        return sum[63:0];
    endfunction

endpackage

// File: rtl/target_channel.sv
// One target channel: sensor index latch, timeout timer, debounce counter and FSM.
module target_channel
    import target_hit_pkg::*;
#(
    parameter int unsigned NUM_SENSORS = 10,
    parameter int unsigned IDX_W       = 4,
    parameter int unsigned TIMER_W     = 32,
    parameter int unsigned DEBOUNCE    = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NUM_SENSORS-1:0] sensor_i,     // already synchronised
    input  logic                   arm_i,
    input  logic                   ack_i,
    input  logic [IDX_W-1:0]       idx_i,
    input  logic [TIMER_W-1:0]     timer_len_i,
    output logic                   active_o,
    output logic                   hit_o,
    output logic                   miss_o,
    output logic                   hit_latched_o,
    output logic                   hit_set_o     // qualification this cycle, feeds the score
);

    localparam int unsigned    CntW    = dbc_cnt_w(DEBOUNCE);
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE - 1);

    chan_state_t        state_q;
    logic [IDX_W-1:0]   idx_q;
    logic [TIMER_W-1:0] timer_q;
    logic [CntW-1:0]    cnt_q;
    logic               active_q;
    logic               hit_q;
    logic               miss_q;
    logic               latched_q;

    logic sel;
    logic hit_qual;
    logic expire;

    // Select the latched sensor; indices past the array read as 0.
    always_comb begin
        sel = 1'b0;
        for (int s = 0; s < NUM_SENSORS; s++) begin
            if (32'(idx_q) == 32'(s)) begin
                sel = sensor_i[s];
            end
        end
    end

    // Qualification and expiry conditions for the upcoming edge.
    always_comb begin
        hit_qual  = (state_q == ARMED) && sel && (cnt_q == CntLast);
        expire    = (state_q == ARMED) && (timer_q == TIMER_W'(1));
        // A re-arm aborts the window, so it also suppresses a pending hit.
        hit_set_o = hit_qual && !arm_i;
    end

    // Channel FSM with registered outputs; arm overrides everything else.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            timer_q   <= '0;
            cnt_q     <= '0;
            active_q  <= 1'b0;
            hit_q     <= 1'b0;
            miss_q    <= 1'b0;
            latched_q <= 1'b0;
        end else begin
            hit_q  <= 1'b0;
            miss_q <= 1'b0;
            if (arm_i) begin
                state_q   <= ARMED;
                idx_q     <= idx_i;
                timer_q   <= (timer_len_i == '0) ? TIMER_W'(1) : timer_len_i;
                cnt_q     <= '0;
                active_q  <= 1'b1;
                latched_q <= 1'b0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                    end
                    ARMED: begin
                        timer_q <= timer_q - TIMER_W'(1);
                        if (hit_qual) begin
                            state_q   <= HIT;
                            hit_q     <= 1'b1;
                            latched_q <= 1'b1;
                            active_q  <= 1'b0;
                        end else if (expire) begin
                            state_q  <= MISS;
                            miss_q   <= 1'b1;
                            active_q <= 1'b0;
                        end else if (sel) begin
                            cnt_q <= cnt_q + CntW'(1);
                        end else begin
                            cnt_q <= '0;
                        end
                    end
                    HIT, MISS: begin
                        if (ack_i) begin
                            state_q   <= IDLE;
                            latched_q <= 1'b0;
                        end
                    end
                endcase
            end
        end
    end

    assign active_o      = active_q;
    assign hit_o         = hit_q;
    assign miss_o        = miss_q;
    assign hit_latched_o = latched_q;

endmodule

// File: rtl/target_hit_tracker.sv
// Multi-channel hit tracker: sensor synchroniser, target channels and saturating score.
module target_hit_tracker
    import target_hit_pkg::*;
#(
    parameter int unsigned NUM_TARGETS = 2,
    parameter int unsigned NUM_SENSORS = 10,
    parameter int unsigned IDX_W       = 4,
    parameter int unsigned TIMER_W     = 32,
    parameter int unsigned DEBOUNCE    = 4,
    parameter int unsigned SCORE_W     = 32,
    parameter int unsigned HIT_POINTS  = 1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [NUM_SENSORS-1:0]       photo_array_i,
    input  logic [NUM_TARGETS-1:0]       arm_i,
    input  logic [NUM_TARGETS*IDX_W-1:0] target_idx_i,
    input  logic [TIMER_W-1:0]           timer_len_i,
    input  logic [NUM_TARGETS-1:0]       ack_i,
    input  logic                         score_clr_i,
    output logic [NUM_TARGETS-1:0]       active_o,
    output logic [NUM_TARGETS-1:0]       hit_o,
    output logic [NUM_TARGETS-1:0]       miss_o,
    output logic [NUM_TARGETS-1:0]       hit_latched_o,
    output logic [SCORE_W-1:0]           score_o
);

    localparam int unsigned HitCntW = $clog2(NUM_TARGETS + 1);

    logic [NUM_SENSORS-1:0] sync1_q;
    logic [NUM_SENSORS-1:0] sync2_q;
    logic [NUM_TARGETS-1:0] hit_set;
    logic [HitCntW-1:0]     hit_cnt;
    logic [63:0]            gain;
    logic [63:0]            base;
    logic [SCORE_W-1:0]     score_d;
    logic [SCORE_W-1:0]     score_q;

    // Two-flop synchroniser for the asynchronous photo sensors.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= photo_array_i;
            sync2_q <= sync1_q;
        end
    end

    for (genvar g = 0; g < NUM_TARGETS; g++) begin : g_chan
        target_channel #(
            .NUM_SENSORS(NUM_SENSORS),
            .IDX_W      (IDX_W),
            .TIMER_W    (TIMER_W),
            .DEBOUNCE   (DEBOUNCE)
        ) u_chan (
            .clk_i        (clk_i),
            .rst_i        (rst_i),
            .sensor_i     (sync2_q),
            .arm_i        (arm_i[g]),
            .ack_i        (ack_i[g]),
            .idx_i        (target_idx_i[g*IDX_W +: IDX_W]),
            .timer_len_i  (timer_len_i),
            .active_o     (active_o[g]),
            .hit_o        (hit_o[g]),
            .miss_o       (miss_o[g]),
            .hit_latched_o(hit_latched_o[g]),
            .hit_set_o    (hit_set[g])
        );
    end

    // Popcount of this cycle's qualifications and the saturating next score.
    always_comb begin
        hit_cnt = '0;
        for (int i = 0; i < NUM_TARGETS; i++) begin
            hit_cnt = hit_cnt + HitCntW'(hit_set[i]);
        end
        gain    = 64'(hit_cnt) * 64'(HIT_POINTS);
        // A clear drops the old value but keeps same-cycle hits.
        base    = score_clr_i ? 64'd0 : 64'(score_q);
        score_d = SCORE_W'(sat_add(base, gain, SCORE_W));
    end

    // Score register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            score_q <= '0;
        end else begin
            score_q <= score_d;
        end
    end

    assign score_o = score_q;

endmodule

// File: tb/tb_target_hit_tracker.sv
// Directed bench for target_hit_tracker; a second instance checks score saturation.
module tb_target_hit_tracker;

    logic        clk;
    logic        rst;
    logic [9:0]  photo;
    logic [1:0]  arm;
    logic [7:0]  idx;
    logic [31:0] len;
    logic [1:0]  ack;
    logic        score_clr;
    logic        score_clr_sat;

    logic [1:0]  active, hit, miss, latched;
    logic [31:0] score;
    logic [1:0]  active_s, hit_s, miss_s, latched_s;
    logic [3:0]  score_s;

    int n_tests = 0;
    int n_fail  = 0;
    logic seen;

    target_hit_tracker u_dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .photo_array_i(photo),
        .arm_i        (arm),
        .target_idx_i (idx),
        .timer_len_i  (len),
        .ack_i        (ack),
        .score_clr_i  (score_clr),
        .active_o     (active),
        .hit_o        (hit),
        .miss_o       (miss),
        .hit_latched_o(latched),
        .score_o      (score)
    );

    target_hit_tracker #(
        .SCORE_W   (4),
        .HIT_POINTS(3)
    ) u_dut_sat (
        .clk_i        (clk),
        .rst_i        (rst),
        .photo_array_i(photo),
        .arm_i        (arm),
        .target_idx_i (idx),
        .timer_len_i  (len),
        .ack_i        (ack),
        .score_clr_i  (score_clr_sat),
        .active_o     (active_s),
        .hit_o        (hit_s),
        .miss_o       (miss_s),
        .hit_latched_o(latched_s),
        .score_o      (score_s)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, landing 1 time unit after the last one.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst = 1'b0; photo = '0; arm = '0; idx = '0; len = '0; ack = '0;
        score_clr = 1'b0; score_clr_sat = 1'b0;
        #1 rst = 1'b1;
        #2;
        check_eq("rst_active", 64'(active), 64'(2'b00));
        check_eq("rst_latched", 64'(latched), 64'(2'b00));
        check_eq("rst_score", 64'(score), 64'(0));
        step(2);
        check_eq("rst_hit_miss", 64'({hit, miss}), 64'(4'b0000));
        rst = 1'b0;
        step(1);

        // Basic hit on ch0, sensor 3.
        idx[3:0] = 4'd3; len = 32'd100; arm = 2'b01;
        step(1);
        arm = 2'b00;
        check_eq("basic_active", 64'(active), 64'(2'b01));
        photo[3] = 1'b1;
        step(5);
        check_eq("basic_no_early_hit", 64'(hit), 64'(2'b00));
        step(1);
        check_eq("basic_hit", 64'(hit), 64'(2'b01));
        check_eq("basic_latched", 64'(latched), 64'(2'b01));
        check_eq("basic_active_off", 64'(active), 64'(2'b00));
        check_eq("basic_score", 64'(score), 64'(1));
        check_eq("basic_score_sat", 64'(score_s), 64'(3));
        step(1);
        check_eq("basic_pulse_end", 64'(hit), 64'(2'b00));
        check_eq("basic_latched_hold", 64'(latched), 64'(2'b01));
        ack = 2'b01;
        step(1);
        ack = 2'b00;
        check_eq("basic_ack", 64'(latched), 64'(2'b00));
        photo = '0;

        // Timeout on ch1, sensor 9, length 20.
        idx[7:4] = 4'd9; len = 32'd20; arm = 2'b10;
        step(1);
        arm = 2'b00;
        step(19);
        check_eq("to_no_early_miss", 64'(miss), 64'(2'b00));
        check_eq("to_active", 64'(active), 64'(2'b10));
        step(1);
        check_eq("to_miss", 64'(miss), 64'(2'b10));
        check_eq("to_active_off", 64'(active), 64'(2'b00));
        check_eq("to_score", 64'(score), 64'(1));
        step(1);
        check_eq("to_pulse_end", 64'(miss), 64'(2'b00));
        ack = 2'b10;
        step(1);
        ack = 2'b00;

        // Out-of-range index never sees the (all-high) sensors.
        idx[7:4] = 4'd12; len = 32'd5; photo = '1; arm = 2'b10;
        step(1);
        arm = 2'b00;
        step(4);
        check_eq("oor_no_early_miss", 64'(miss), 64'(2'b00));
        step(1);
        check_eq("oor_miss", 64'(miss), 64'(2'b10));
        check_eq("oor_no_hit", 64'(hit), 64'(2'b00));
        ack = 2'b10;
        step(1);
        ack = 2'b00;
        photo = '0;
        step(3);

        // Glitch of 3 cycles is rejected, 4 cycles qualifies.
        idx[3:0] = 4'd3; len = 32'd100; arm = 2'b01;
        step(1);
        arm = 2'b00;
        photo[3] = 1'b1;
        step(3);
        photo[3] = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            seen = seen | hit[0];
        end
        check_eq("glitch_no_hit", 64'(seen), 64'(0));
        check_eq("glitch_still_armed", 64'(active), 64'(2'b01));
        photo[3] = 1'b1;
        step(4);
        photo[3] = 1'b0;
        step(1);
        check_eq("pulse4_no_early_hit", 64'(hit), 64'(2'b00));
        step(1);
        check_eq("pulse4_hit", 64'(hit), 64'(2'b01));
        check_eq("pulse4_score", 64'(score), 64'(2));
        check_eq("pulse4_score_sat", 64'(score_s), 64'(6));
        ack = 2'b01;
        step(1);
        ack = 2'b00;

        // Both channels qualify on the same edge.
        idx = {4'd5, 4'd3}; len = 32'd100; arm = 2'b11;
        step(1);
        arm = 2'b00;
        photo[3] = 1'b1; photo[5] = 1'b1;
        step(6);
        check_eq("both_hit", 64'(hit), 64'(2'b11));
        check_eq("both_score", 64'(score), 64'(4));
        check_eq("both_score_sat", 64'(score_s), 64'(12));
        ack = 2'b11;
        step(1);
        ack = 2'b00;

        // Qualification and expiry on the same edge: hit only.
        idx[3:0] = 4'd3; len = 32'd4; arm = 2'b01;
        step(1);
        arm = 2'b00;
        step(3);
        check_eq("coin_quiet", 64'({hit, miss}), 64'(4'b0000));
        step(1);
        check_eq("coin_hit", 64'(hit), 64'(2'b01));
        check_eq("coin_no_miss", 64'(miss), 64'(2'b00));
        check_eq("coin_latched", 64'(latched), 64'(2'b01));
        check_eq("coin_score", 64'(score), 64'(5));
        check_eq("coin_score_sat", 64'(score_s), 64'(15));

        // Arm and ack together while in HIT: arm wins.
        photo = '0;
        step(3);
        len = 32'd50; arm = 2'b01; ack = 2'b01;
        step(1);
        arm = 2'b00; ack = 2'b00;
        check_eq("armack_active", 64'(active), 64'(2'b01));
        check_eq("armack_latched", 64'(latched), 64'(2'b00));

        // Score clear on the same edge as a hit keeps that hit.
        photo[3] = 1'b1;
        step(5);
        check_eq("clr_no_early_hit", 64'(hit), 64'(2'b00));
        score_clr = 1'b1;
        step(1);
        score_clr = 1'b0;
        check_eq("clr_hit", 64'(hit), 64'(2'b01));
        check_eq("clr_score", 64'(score), 64'(1));
        check_eq("sat_stuck", 64'(score_s), 64'(15));

        // Asynchronous reset in the middle of an armed window.
        ack = 2'b01;
        step(1);
        ack = 2'b00;
        len = 32'd100; arm = 2'b01;
        step(1);
        arm = 2'b00;
        step(2);
        #3 rst = 1'b1;
        #1;
        check_eq("arst_active", 64'(active), 64'(2'b00));
        check_eq("arst_score", 64'(score), 64'(0));
        check_eq("arst_score_sat", 64'(score_s), 64'(0));
        check_eq("arst_latched", 64'(latched), 64'(2'b00));
        #1 rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            seen = seen | hit[0] | active[0];
        end
        check_eq("arst_stays_idle", 64'(seen), 64'(0));
        arm = 2'b01;
        step(1);
        arm = 2'b00;
        step(3);
        check_eq("rearm_no_early_hit", 64'(hit), 64'(2'b00));
        step(1);
        check_eq("rearm_hit", 64'(hit), 64'(2'b01));
        check_eq("rearm_score", 64'(score), 64'(1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/target_hit_tracker.md
# target_hit_tracker

Parametrised hit-detection and scoring block for the game datapath, replacing the fixed pair of photo-sensor SR latches and the hard-wired timers A/B. Supports NUM_TARGETS independent target channels. Each channel selects one photo sensor, debounces it, and runs its own timeout window. A channel reports hit or miss and holds that status until the processor acknowledges it. A shared saturating accumulator counts hit points and drives the score register readback.

## Interface
- NUM_TARGETS, 2, number of independent target channels
- NUM_SENSORS, 10, width of the photo sensor array
- IDX_W, 4, width of each channel's sensor index
- TIMER_W, 32, width of the timeout window length
- DEBOUNCE, 4, consecutive synchronised high cycles that qualify a hit (≥1)
- SCORE_W, 32, score accumulator width
- HIT_POINTS, 1, points added per qualified hit
- clock  in  1  single system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- photo_array  in  NUM_SENSORS  raw photo sensor levels, asynchronous to clock
- arm  in  NUM_TARGETS  per-channel one-cycle arm/re-arm strobe
- target_idx  in  NUM_TARGETS*IDX_W  sensor index per channel; channel i uses bits [i*IDX_W +: IDX_W]; sampled on arm
- timer_len  in  TIMER_W  timeout window in cycles; shared, sampled on arm
- ack  in  NUM_TARGETS  per-channel strobe that returns a HIT/MISS channel to IDLE
- score_clr  in  1  clears the score
- active  out  NUM_TARGETS  channel is in ARMED
- hit  out  NUM_TARGETS  one-cycle pulse on hit qualification
- miss  out  NUM_TARGETS  one-cycle pulse on timeout
- hit_latched  out  NUM_TARGETS  high while the channel is in HIT
- score  out  SCORE_W  accumulated points

## Operation
- Synchronisation: photo_array passes through a 2-flop synchroniser, shared by all channels.
- Per-channel states:
  - IDLE: arm → ARMED.
  - ARMED: qualify → HIT; timer expiry → MISS.
  - HIT: ack → IDLE.
  - MISS: ack → IDLE.
- On arm (any state):
  - latch target_idx and load timer with timer_len;
  - timer_len = 0 is treated as 1;
  - clear the debounce counter;
  - enter ARMED.
- arm and ack asserted in the same cycle: arm wins.
- ARMED:
  - The timer decrements every cycle.
  - The debounce counter increments while the selected synced sensor is 1 and clears to 0 when it is 0.
  - Counter reaching DEBOUNCE → HIT and a hit pulse.
  - Timer reaching 0 → MISS and a miss pulse.
  - Both in the same cycle: HIT wins, and no miss pulse is issued.
- target_idx ≥ NUM_SENSORS: the selected sensor reads 0, so the channel can only time out.
- ack in IDLE or ARMED is ignored.
- Score update:
  - Each cycle, score += (number of hit pulses) × HIT_POINTS.
  - The result saturates at 2^SCORE_W−1 and never wraps.
  - score_clr loads score with that cycle's hit-pulse contribution (clear takes priority over the prior value; same-cycle hits still count).
- Reset: every channel returns to IDLE; score, timers and counters go to 0; synchroniser flops go to 0.

## Timing
- All outputs are registered.
- Reset values: active, hit, miss, hit_latched = 0; score = 0.
- arm at edge a: active is high from edge a.
- Hit latency:
  - sensor high and stable before edge k and held → hit pulse high for exactly one cycle after edge k+1+DEBOUNCE;
  - hit_latched rises together with the hit pulse;
  - score reflects the hit in the same cycle as the pulse.
- Miss timing: arm at edge a with length L, no hit → miss pulse after edge a+L; active falls at that same edge.
- A sensor glitch shorter than DEBOUNCE synced cycles never produces a hit.
- Re-arm while ARMED restarts the window from the new edge; no pulse is emitted for the aborted window.
- Reset asserted mid-window: outputs clear immediately (asynchronous). After deassertion a channel only leaves IDLE on a new arm.

## Structure
- Package target_hit_pkg holds:
  - the state enum chan_state_t {IDLE, ARMED, HIT, MISS};
  - the debounce counter width function clog2(DEBOUNCE+1);
  - a saturating-add helper.
- Sub-module target_channel holds one channel's FSM, timer, debounce counter and index latch.
- The top level holds:
  - the synchroniser;
  - a generate loop of NUM_TARGETS target_channel instances;
  - the popcount of hit pulses;
  - the saturating score accumulator.

## Test plan
- Basic hit: NUM_TARGETS=2, DEBOUNCE=4; arm ch0 idx 3, len 100; hold photo_array[3]=1 → hit[0] one pulse at edge k+5; score=1; hit_latched[0]=1 until ack[0]; active[0]=0 after the hit.
- Timeout: arm ch1 idx 9, len 20, sensor low → miss[1] 20 cycles after arm; score unchanged; index 12 (out of range) with len 5 → miss after 5 cycles.
- Glitch reject: 3-cycle pulse on the selected sensor with DEBOUNCE=4 → no hit; a 4-cycle pulse → hit.
- Simultaneous events:
  - both channels qualify in the same cycle → score += 2;
  - qualification and expiry coincide → hit only;
  - arm and ack together → ARMED;
  - score_clr with one hit pulse in the same cycle → score=1.
- Saturation: SCORE_W=4, HIT_POINTS=3, drive six hits → score sticks at 15.
- Reset mid-window: reset asserted asynchronously while ch0 is ARMED → all outputs 0 before the next edge; after release, no hit while the sensor is held high until a new arm.
